uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (LSB first, 1 start, 8 data, 1 stop, no parity)
// on the 12 MHz fabric clock. The rx line is brought in through a two-flop
// synchroniser; every decision in the frame FSM uses the synchronised value.
// Received bytes are presented through a valid/ack holding stage.
// Optional feature macro: UART_RX_FIFO_EN. When it is defined, the single-entry
// holding register becomes a FIFO_DEPTH-entry circular FIFO.
module uart_rx #(
  parameter int CLKS_PER_BIT = 1251
`ifdef UART_RX_FIFO_EN
  ,
  parameter int FIFO_DEPTH   = 4
`endif
) (
  input  logic       clk12MHz,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] recvData,
  output logic       recvValid,
  input  logic       recvAck,
  output logic       frameErr,
  output logic       overrun
);

  // Counter reload values: half a bit to reach the middle of the start bit,
  // then one full bit between successive mid-bit samples.
  localparam logic [15:0] HALF_LOAD = 16'((CLKS_PER_BIT / 2) - 1);
  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } state_t;

  // Synchroniser flops; both idle high so reset never looks like a start bit.
  logic        rx_meta_q;
  logic        rx_sync_q;
  logic        rx_s;

  // Frame FSM state and datapath.
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        done_s;   // stop bit sampled high: sh_q holds a complete byte
  logic        ferr_s;   // stop bit sampled low

  // Output stage registers.
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q;
  logic        overrun_q;
  logic        ovr_s;
  logic        pop_s;

  assign rx_s = rx_sync_q;

  // Two-flop synchroniser for the asynchronous rx line.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Frame FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  // Frame FSM next state: mid-bit sampling, glitch rejection, break handling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    done_s  = 1'b0;
    ferr_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_s == 1'b0) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s == 1'b0) begin
          state_d = ST_DATA;
          cnt_d   = BIT_LOAD;
          idx_d   = 3'd0;
        end else begin
          // Line went back high before mid-start: treat as a glitch.
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          sh_d  = {rx_s, sh_q[7:1]};
          cnt_d = BIT_LOAD;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s == 1'b1) begin
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ferr_s  = 1'b1;
          state_d = ST_BRK;
        end
      end
      ST_BRK: begin
        // A line held low must return high before a new frame can start.
        if (rx_s == 1'b1) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BRK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Consumer pop: an ack is only meaningful while a byte is presented.
  assign pop_s = recvAck & valid_q;

`ifdef UART_RX_FIFO_EN

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW + 1)'(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   count_s;
  logic [AW:0]   count_next_s;
  logic [AW-1:0] rd_next_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;

  // FIFO occupancy, push/pop decisions and the next head value to present.
  always_comb begin
    count_s      = wptr_q - rptr_q;
    full_s       = (count_s == PTR_DEPTH);
    empty_s      = (count_s == (AW + 1)'(0));
    // When full, a same-cycle pop frees the slot the new byte needs.
    push_s       = done_s & (~full_s | pop_s);
    ovr_s        = done_s & full_s & ~pop_s;
    wptr_d       = push_s ? (wptr_q + PTR_ONE) : wptr_q;
    rptr_d       = pop_s  ? (rptr_q + PTR_ONE) : rptr_q;
    count_next_s = wptr_d - rptr_d;
    rd_next_s    = rptr_q[AW-1:0] + AW'(1);
    valid_d      = (count_next_s != (AW + 1)'(0));
    if (count_next_s == (AW + 1)'(0)) begin
      data_d = data_q;
    end else if (pop_s) begin
      if (count_s == PTR_ONE) begin
        // Only entry popped while a new one arrives: new byte becomes head.
        data_d = sh_q;
      end else begin
        data_d = mem_q[rd_next_s];
      end
    end else if (empty_s) begin
      data_d = sh_q;
    end else begin
      data_d = data_q;
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      wptr_q <= (AW + 1)'(0);
      rptr_q <= (AW + 1)'(0);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (push_s) begin
        mem_q[wptr_q[AW-1:0]] <= sh_q;
      end
    end
  end

`else

  // Single-entry holding register: load, pop, and overrun decisions.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovr_s   = 1'b0;
    if (done_s) begin
      if (!valid_q || pop_s) begin
        valid_d = 1'b1;
        data_d  = sh_q;
      end else begin
        // Full and not being drained: keep the old byte, drop the new one.
        ovr_s = 1'b1;
      end
    end else if (pop_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

`endif

  // Registered outputs: presented byte, valid flag and status pulses.
  always_ff @(posedge clk12MHz) begin
    if (!resetn) begin
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= ferr_s;
      overrun_q   <= ovr_s;
    end
  end

  assign recvData  = data_q;
  assign recvValid = valid_q;
  assign frameErr  = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scoreboard bench for uart_rx with CLKS_PER_BIT=16.
// Stimulus pushes expected bytes into a queue; a monitor pops and compares
// whenever the consumer acks a presented byte, and counts status pulses.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk12MHz = 1'b0;
  logic       resetn   = 1'b0;
  logic       rx       = 1'b1;
  logic       recvAck  = 1'b0;
  logic [7:0] recvData;
  logic       recvValid;
  logic       frameErr;
  logic       overrun;

  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         rise_cyc = -1;
  int         t0       = 0;
  int         ovr_base = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] exp_q [$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk12MHz (clk12MHz),
    .resetn   (resetn),
    .rx       (rx),
    .recvData (recvData),
    .recvValid(recvValid),
    .recvAck  (recvAck),
    .frameErr (frameErr),
    .overrun  (overrun)
  );

  always #5 clk12MHz = ~clk12MHz;

  // Cycle counter advanced on every rising edge.
  initial begin
    forever begin
      @(posedge clk12MHz);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pulse counting and scoreboard pops on each acked byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk12MHz);
      if (frameErr === 1'b1) ferr_cnt = ferr_cnt + 1;
      if (overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
      if (recvValid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
      valid_prev = recvValid;
      if (recvValid === 1'b1 && recvAck === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL pop_unexpected got %0h expected none", recvData);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", {24'd0, recvData}, {24'd0, e});
        end
      end
    end
  end

  // Drive one frame starting just after the next rising edge; t0 marks it.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk12MHz);
    t0 = cyc;
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk12MHz);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk12MHz);
    end
    #1 rx = stop_bit;
    repeat (CPB) @(posedge clk12MHz);
    #1;
  endtask

  task automatic do_ack();
    @(posedge clk12MHz);
    #1 recvAck = 1'b1;
    @(posedge clk12MHz);
    #1 recvAck = 1'b0;
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clk12MHz);
    #1;
    chk("rst_valid", {31'd0, recvValid}, 32'd0);
    chk("rst_data", {24'd0, recvData}, 32'd0);
    chk("rst_ferr", {31'd0, frameErr}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    resetn = 1'b1;
    repeat (4) @(posedge clk12MHz);
    #1;

    // 0xA5 clean frame, no ack: valid 155 cycles after the start edge
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    chk("rise_latency", rise_cyc - t0, 32'd155);
    chk("a5_valid", {31'd0, recvValid}, 32'd1);
    chk("a5_data", {24'd0, recvData}, 32'hA5);
    chk("a5_ferr_cnt", ferr_cnt, 32'd0);
    chk("a5_ovr_cnt", ovr_cnt, 32'd0);

`ifdef UART_RX_FIFO_EN
    do_ack();
    chk("a5_popped", {31'd0, recvValid}, 32'd0);
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    chk("fifo_ovr_cnt", ovr_cnt, 32'd1);
    chk("fifo_valid_full", {31'd0, recvValid}, 32'd1);
    chk("fifo_head", {24'd0, recvData}, 32'h01);
    for (int k = 0; k < 4; k++) do_ack();
    chk("fifo_drained", {31'd0, recvValid}, 32'd0);
`else
    // 0x3C while 0xA5 still held: overrun, 0xA5 kept
    send_frame(8'h3C, 1'b1);
    chk("ovr_cnt", ovr_cnt, 32'd1);
    chk("ovr_keep_data", {24'd0, recvData}, 32'hA5);
    do_ack();
    chk("ack_clears_valid", {31'd0, recvValid}, 32'd0);
`endif
    ovr_base = ovr_cnt;

    // 0x55 with a low stop bit, then line held low (break)
    send_frame(8'h55, 1'b0);
    repeat (40) @(posedge clk12MHz);
    #1;
    chk("ferr_cnt", ferr_cnt, 32'd1);
    chk("ferr_no_byte", {31'd0, recvValid}, 32'd0);
    rx = 1'b1;
    repeat (200) @(posedge clk12MHz);
    #1;
    chk("break_no_retrigger", {31'd0, recvValid}, 32'd0);
    chk("break_ferr_once", ferr_cnt, 32'd1);

    // 4-cycle glitch on an idle line
    @(posedge clk12MHz);
    #1 rx = 1'b0;
    repeat (4) @(posedge clk12MHz);
    #1 rx = 1'b1;
    repeat (50) @(posedge clk12MHz);
    #1;
    chk("glitch_valid", {31'd0, recvValid}, 32'd0);
    chk("glitch_ferr", ferr_cnt, 32'd1);
    chk("glitch_ovr", ovr_cnt, ovr_base);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    chk("after_glitch_valid", {31'd0, recvValid}, 32'd1);
    do_ack();

    // Reset pulse in the middle of 0xFF data bits, then 0x81
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk12MHz);
        repeat (60) @(posedge clk12MHz);
        #1 resetn = 1'b0;
        @(posedge clk12MHz);
        #1 resetn = 1'b1;
      end
    join
    repeat (20) @(posedge clk12MHz);
    #1;
    chk("rst_mid_no_byte", {31'd0, recvValid}, 32'd0);
    chk("rst_mid_ferr", ferr_cnt, 32'd1);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    chk("after_rst_valid", {31'd0, recvValid}, 32'd1);
    chk("after_rst_data", {24'd0, recvData}, 32'h81);
    do_ack();

    // Completion on the same cycle as an ack of the held byte
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(posedge clk12MHz);
        repeat (154) @(posedge clk12MHz);
        #1 recvAck = 1'b1;
        @(posedge clk12MHz);
        #1 recvAck = 1'b0;
      end
    join
    chk("swap_valid", {31'd0, recvValid}, 32'd1);
    chk("swap_data", {24'd0, recvData}, 32'h22);
    chk("swap_no_ovr", ovr_cnt, ovr_base);
    do_ack();
    chk("final_valid", {31'd0, recvValid}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
